leb128_decoder: RTL and testbench
=================================

# leb128_decoder

Byte-serial LEB128 immediate decoder on the fetch side of `cpu`. It sits between the byte stream read from `genrom` and the operand registers of the execute stage. It accepts one encoded byte per cycle over a valid/ready handshake and produces a fully decoded, width-checked signed or unsigned immediate (local index, `i32.const`/`i64.const` operand, branch depth). It also reports the encoded byte length so the fetch unit can advance `pc`.

## Interface
- `MAX_BITS`, default 64: widest supported target. Legal values are 32 and 64. With 32, 64-bit decode requests trap, mirroring a core built without 64-bit support.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `start`  in  1  request a new decode; sampled only in IDLE.
- `is_signed`  in  1  sampled with `start`: 1 = SLEB128, 0 = ULEB128.
- `wide`  in  1  sampled with `start`: 1 = 64-bit target, 0 = 32-bit target.
- `in_valid`  in  1  `in_data` carries a byte.
- `in_data`  in  8  encoded byte; bit 7 = continuation, bits 6:0 = payload.
- `in_ready`  out  1  decoder accepts a byte this cycle.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `value`  out  64  decoded value. 32-bit results sit in [31:0] with [63:32] = 0.
- `length`  out  4  bytes consumed, 1..10; 0 on the width trap.
- `error`  out  1  qualifies `out_valid`; the encoding was illegal.
- `busy`  out  1  state is not IDLE.

## Operation
States: IDLE, ACCUM, DONE.

- **IDLE**
  - `in_ready` = 0.
  - On `start`: latch `is_signed` and `wide`, clear the accumulator, set the count to 0.
  - If `wide` = 1 and `MAX_BITS` = 32: go to DONE with `error` = 1, `length` = 0, `value` = 0.
  - Otherwise go to ACCUM.
- **ACCUM**
  - `in_ready` = 1.
  - Each accepted byte (`in_valid` & `in_ready`) ORs payload << (7·count) into the accumulator and increments the count.
  - Byte limit N is 5 for 32-bit targets and 10 for 64-bit targets.
  - Terminal byte (bit 7 = 0) at count < N: go to DONE.
- **Final-byte legality**, checked when count+1 = N:
  - Bit 7 must be 0.
  - Unsigned 32: bits 6:4 must be 0.
  - Signed 32: bits 6:4 must equal bit 3.
  - Unsigned 64: bits 6:1 must be 0.
  - Signed 64: bits 6:1 must equal bit 0.
  - Any violation: go to DONE with `error` = 1 and `value` = 0. `length` = count+1 (the failing byte is consumed).
- **Sign extension** (signed only): if the terminal byte's bit 6 = 1 and 7·(count+1) < target width, fill the bits from 7·(count+1) up to width−1 with 1. For 32-bit targets, [63:32] stays 0.
- **DONE**
  - `out_valid` = 1, `in_ready` = 0.
  - `value`, `length`, `error` held stable until `out_valid` & `out_ready`, then return to IDLE.
- `start` is ignored while `busy` = 1.
- `in_valid` is ignored outside ACCUM.

## Timing
- Reset (asynchronous, immediate):
  - State = IDLE.
  - `in_ready`, `out_valid`, `error`, `busy` = 0.
  - `value` = 0, `length` = 0.
- Reset asserted mid-decode discards the partial value. No `out_valid` is produced for the aborted decode.
- Handshake and latency:
  - `start` sampled at edge T gives ACCUM and `in_ready` = 1 from T+1.
  - One byte per cycle max.
  - Terminal byte accepted at edge E: `out_valid` = 1 and `in_ready` = 0 in the cycle after E.
  - Total latency from `start` to `out_valid` is k+1 cycles for a k-byte encoding, with no input stalls.
- Input stall: `in_valid` low in ACCUM holds the state with no count change.
- Output stall: `out_ready` low holds DONE indefinitely; outputs are stable.
- Result acceptance at edge F: `busy` = 0 and `out_valid` = 0 from F+1. The next `start` is sampled no earlier than F+1, so there is one idle cycle between decodes.
- Width trap: `out_valid` = 1, `error` = 1 one cycle after `start`.
- `value`, `length`, `error` are registered. They are 0 in IDLE and ACCUM and driven only in DONE.

## Test plan
- Unsigned 32, bytes E5 8E 26 back-to-back → `out_valid` 4 cycles after `start`, `value` = 0x0000000000098765 (624485), `length` = 3, `error` = 0.
- Signed 64, bytes C0 BB 78 → `value` = 0xFFFFFFFFFFFE1DC0 (−123456), `length` = 3.
- Single byte, checking sign extension:
  - Signed 32, byte 7F → `value` = 0x00000000FFFFFFFF, `length` = 1.
  - Unsigned 32, byte 7F → `value` = 0x7F.
- Width boundaries, unsigned 32:
  - FF FF FF FF 0F → `value` = 0xFFFFFFFF, `length` = 5.
  - FF FF FF FF 1F → `error` = 1, `value` = 0, `length` = 5.
  - 80 80 80 80 80 → `error` = 1 at the fifth byte, with no sixth byte accepted (`in_ready` drops).
- Stalls:
  - `in_valid` gaps of 2 cycles between bytes of E5 8E 26 → same result as the first scenario.
  - `out_ready` held low 3 cycles → `out_valid`/`value` stable; a `start` pulse during DONE is ignored.
- Traps and reset:
  - Instance with `MAX_BITS` = 32, `start` with `wide` = 1 → `out_valid` & `error` next cycle, `length` = 0.
  - `reset` asserted low after 2 bytes of a decode → all outputs 0 immediately.
  - After `reset` is released, a fresh decode of E5 8E 26 → 0x98765.

Source files
------------

// File: rtl/leb128_decoder.sv
// Purpose: byte-serial ULEB128/SLEB128 immediate decoder (32/64-bit targets, width-checked).
// Latency: k+1 cycles from start to out_valid for a k-byte encoding; width trap reports 1 cycle after start.
// Backpressure: in_ready only in ACCUM (one byte/cycle); DONE holds all outputs until out_ready.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   start/is_signed/wide  decode request and its mode, sampled only in IDLE
//   in_valid/in_ready/in_data    encoded byte stream (bit 7 = continuation)
//   out_valid/out_ready   result handshake; value/length/error valid with out_valid
//   busy                  decoder is not IDLE
module leb128_decoder #(
    parameter int MAX_BITS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_signed,
    input  logic        wide,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] value,
    output logic [3:0]  length,
    output logic        error,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam bit WIDE_OK = (MAX_BITS == 64);

    state_t      state;
    logic        sgn_q;
    logic        wide_q;
    logic [63:0] acc;
    logic [3:0]  count;

    logic [6:0]  payload;
    logic [6:0]  shamt;
    logic [6:0]  shamt_next;
    logic [63:0] acc_next;
    logic [63:0] fill;
    logic [63:0] wmask;
    logic [63:0] result;
    logic [3:0]  limit;
    logic        last_byte;
    logic        legal_bits;
    logic        legal;

    always_comb begin
        payload    = in_data[6:0];
        shamt      = {3'd0, count} * 7'd7;
        shamt_next = shamt + 7'd7;
        // Bits shifted past bit 63 fall off; only the final byte can reach them
        // and its legality check already constrains those bits.
        acc_next   = acc | ({57'd0, payload} << shamt);
        limit      = wide_q ? 4'd10 : 4'd5;
        last_byte  = (count + 4'd1) == limit;

        // Final byte must keep the value inside the target range: for unsigned
        // the bits above the width are zero, for signed they replicate the sign.
        case ({wide_q, sgn_q})
            2'b00:   legal_bits = (payload[6:4] == 3'b000);
            2'b01:   legal_bits = (payload[6:4] == {3{payload[3]}});
            2'b10:   legal_bits = (payload[6:1] == 6'b000000);
            default: legal_bits = (payload[6:1] == {6{payload[0]}});
        endcase
        legal = ~in_data[7] & legal_bits;

        // Sign fill starts just above the last payload bit; the width mask
        // drops anything past bit 31 for 32-bit targets.
        fill   = (shamt_next < 7'd64) ? (~64'd0 << shamt_next) : 64'd0;
        wmask  = wide_q ? ~64'd0 : 64'h0000_0000_FFFF_FFFF;
        result = (acc_next | ((sgn_q && payload[6]) ? fill : 64'd0)) & wmask;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sgn_q     <= 1'b0;
            wide_q    <= 1'b0;
            acc       <= 64'd0;
            count     <= 4'd0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            value     <= 64'd0;
            length    <= 4'd0;
            error     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sgn_q  <= is_signed;
                        wide_q <= wide;
                        acc    <= 64'd0;
                        count  <= 4'd0;
                        busy   <= 1'b1;
                        if (wide && !WIDE_OK) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            error     <= 1'b1;
                            length    <= 4'd0;
                            value     <= 64'd0;
                        end else begin
                            state    <= ACCUM;
                            in_ready <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        if (last_byte && !legal) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            error     <= 1'b1;
                            value     <= 64'd0;
                            length    <= count + 4'd1;
                        end else if (!in_data[7]) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            error     <= 1'b0;
                            value     <= result;
                            length    <= count + 4'd1;
                        end else begin
                            acc   <= acc_next;
                            count <= count + 4'd1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        value     <= 64'd0;
                        length    <= 4'd0;
                        error     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_leb128_decoder.sv
// Purpose: self-checking bench for leb128_decoder (directed cases plus random encodings vs. a reference model).
// Latency: checks start-to-out_valid latency of k+1 cycles on unstalled decodes.
// Backpressure: exercises in_valid gaps and out_ready stalls, and the 32-bit-only width trap.
module tb_leb128_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic        wide = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] value;
    logic [3:0]  length;
    logic        error;
    logic        busy;

    // 32-bit-only instance, used for the width trap
    logic        s_start = 1'b0;
    logic        s_out_ready = 1'b0;
    logic        s_in_ready;
    logic        s_out_valid;
    logic [63:0] s_value;
    logic [3:0]  s_length;
    logic        s_error;
    logic        s_busy;
    logic        s_zero = 1'b0;
    logic [7:0]  s_zero8 = 8'd0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] stim[$];

    always #5 clk = ~clk;

    leb128_decoder #(.MAX_BITS(64)) dut (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed), .wide(wide),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .value(value),
        .length(length), .error(error), .busy(busy)
    );

    leb128_decoder #(.MAX_BITS(32)) dut32 (
        .clk(clk), .reset(reset), .start(s_start), .is_signed(s_zero), .wide(1'b1),
        .in_valid(s_zero), .in_data(s_zero8), .in_ready(s_in_ready),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .value(s_value),
        .length(s_length), .error(s_error), .busy(s_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Reference: decode as an arbitrary-precision integer, then range-check
    // the integer against the target width.
    task automatic model(input bit sgn, input bit wd,
                         output logic [63:0] ev, output int el, output bit ee);
        int n;
        int w;
        int i;
        int bits;
        bit term;
        logic [127:0] acc;
        logic [127:0] hi;
        bit in_range;
        n = wd ? 10 : 5;
        w = wd ? 64 : 32;
        acc = '0;
        term = 0;
        i = 0;
        while (i < n && !term) begin
            acc = acc | (128'(stim[i] & 8'h7f) << (7 * i));
            if (!stim[i][7]) term = 1;
            i++;
        end
        el = i;
        if (!term) begin
            ee = 1;
            ev = '0;
        end else begin
            bits = 7 * el;
            if (sgn && acc[bits-1]) acc = acc | (~128'd0 << bits);
            if (sgn) begin
                hi = $signed(acc) >>> (w - 1);
                in_range = (hi == '0) || (&hi);
            end else begin
                in_range = ((acc >> w) == '0);
            end
            ee = !in_range;
            ev = in_range ? (wd ? acc[63:0] : {32'd0, acc[31:0]}) : 64'd0;
        end
    endtask

    task automatic run_decode(input string tag, input bit sgn, input bit wd,
                              input int gap, input int ostall, input bit use_exp,
                              input logic [63:0] xv, input int xl, input bit xe);
        logic [63:0] ev;
        int el;
        bit ee;
        int cyc;
        int fed;
        int idle;
        bit done;
        model(sgn, wd, ev, el, ee);
        if (use_exp) begin
            ev = xv; el = xl; ee = xe;
        end
        @(negedge clk);
        start = 1'b1; is_signed = sgn; wide = wd;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; fed = 0; idle = 0; done = 0;
        while (!done && cyc < 200) begin
            if (out_valid) begin
                done = 1;
            end else begin
                in_valid = 1'b0;
                if (in_ready && fed < stim.size()) begin
                    if (idle > 0) begin
                        idle--;
                    end else begin
                        in_valid = 1'b1;
                        in_data  = stim[fed];
                        fed++;
                        idle = gap;
                    end
                end
                @(negedge clk);
                cyc++;
            end
        end
        in_valid = 1'b0;
        check({tag, " done"}, done, 1);
        if (!done) return;
        check({tag, " value"}, value, ev);
        check({tag, " length"}, length, el);
        check({tag, " error"}, error, ee);
        check({tag, " bytes_taken"}, fed, el);
        check({tag, " in_ready_low"}, in_ready, 0);
        check({tag, " busy"}, busy, 1);
        if (gap == 0) check({tag, " latency"}, cyc, el + 1);
        for (int s = 0; s < ostall; s++) begin
            start = 1'b1;
            @(negedge clk);
            check({tag, " hold_valid"}, out_valid, 1);
            check({tag, " hold_value"}, value, ev);
            check({tag, " hold_length"}, length, el);
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " idle_valid"}, out_valid, 0);
        check({tag, " idle_busy"}, busy, 0);
        check({tag, " idle_value"}, value, 0);
    endtask

    initial begin
        #2 reset = 1'b0;
        #1;
        check("rst in_ready", in_ready, 0);
        check("rst out_valid", out_valid, 0);
        check("rst busy", busy, 0);
        check("rst value", value, 0);
        check("rst length", length, 0);
        check("rst error", error, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        stim = '{8'hE5, 8'h8E, 8'h26};
        run_decode("u32_basic", 0, 0, 0, 0, 1, 64'h0000_0000_0009_8765, 3, 0);
        stim = '{8'hC0, 8'hBB, 8'h78};
        run_decode("s64_neg", 1, 1, 0, 0, 1, 64'hFFFF_FFFF_FFFE_1DC0, 3, 0);
        stim = '{8'h7F};
        run_decode("s32_7f", 1, 0, 0, 0, 1, 64'h0000_0000_FFFF_FFFF, 1, 0);
        stim = '{8'h7F};
        run_decode("u32_7f", 0, 0, 0, 0, 1, 64'h7F, 1, 0);
        stim = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F};
        run_decode("u32_max", 0, 0, 0, 0, 1, 64'hFFFF_FFFF, 5, 0);
        stim = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h1F};
        run_decode("u32_over", 0, 0, 0, 0, 1, 64'h0, 5, 1);
        stim = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
        run_decode("u32_unterm", 0, 0, 0, 0, 1, 64'h0, 5, 1);
        stim = '{8'hE5, 8'h8E, 8'h26};
        run_decode("in_gap", 0, 0, 2, 0, 1, 64'h0000_0000_0009_8765, 3, 0);
        run_decode("out_stall", 0, 0, 0, 3, 1, 64'h0000_0000_0009_8765, 3, 0);

        // Width trap on the 32-bit-only instance
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        check("trap out_valid", s_out_valid, 1);
        check("trap error", s_error, 1);
        check("trap length", s_length, 0);
        check("trap value", s_value, 0);
        check("trap in_ready", s_in_ready, 0);
        s_out_ready = 1'b1;
        @(negedge clk);
        s_out_ready = 1'b0;
        check("trap idle_busy", s_busy, 0);

        // Reset in the middle of a decode, then a fresh decode
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; wide = 1'b0;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'hE5;
        @(negedge clk);
        in_data = 8'h8E;
        @(negedge clk);
        in_valid = 1'b0;
        check("mid busy_before", busy, 1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst busy", busy, 0);
        check("mid_rst in_ready", in_ready, 0);
        check("mid_rst out_valid", out_valid, 0);
        check("mid_rst value", value, 0);
        check("mid_rst length", length, 0);
        check("mid_rst error", error, 0);
        @(negedge clk);
        reset = 1'b1;
        stim = '{8'hE5, 8'h8E, 8'h26};
        run_decode("after_rst", 0, 0, 0, 0, 1, 64'h0000_0000_0009_8765, 3, 0);

        // Random encodings against the reference model
        for (int it = 0; it < 40; it++) begin
            bit sgn;
            bit wd;
            int n;
            int k;
            logic [7:0] b;
            sgn = 1'($urandom_range(0, 1));
            wd  = 1'($urandom_range(0, 1));
            n = wd ? 10 : 5;
            k = $urandom_range(1, n);
            stim.delete();
            for (int j = 0; j < k - 1; j++) stim.push_back(8'($urandom) | 8'h80);
            b = 8'($urandom) & 8'h7F;
            if (k == n) begin
                if ($urandom_range(0, 1) == 1) begin
                    case ({wd, sgn})
                        2'b00: b = b & 8'h0F;
                        2'b01: b = b[3] ? (b | 8'h70) : (b & 8'h0F);
                        2'b10: b = b & 8'h01;
                        default: b = b[0] ? (b | 8'h7E) : (b & 8'h01);
                    endcase
                end else if ($urandom_range(0, 3) == 0) begin
                    b = b | 8'h80;
                end
            end
            stim.push_back(b);
            run_decode($sformatf("rand%0d", it), sgn, wd, $urandom_range(0, 2),
                       $urandom_range(0, 3), 0, 64'd0, 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
